dual_issue_scheduler: RTL and testbench

- Sits between the decode slots (IF/ID pair register) and the ID/EX register of the two-lane in-order pipeline.
- Each cycle, decides whether the decoded pair issues together, issues split over two cycles, or waits one bubble cycle for a load-use hazard.
- Keeps its own record of which loads are in EX, so that the operand-forwarding muxes only ever receive legal forwarding cases.
- Lane 0 is the only lane with a memory port and the only lane that may carry a control transfer.

---
 rtl/dual_issue_scheduler_pkg.sv | 38 +++
 rtl/dual_issue_scheduler_pair_check.sv | 39 +++
 rtl/dual_issue_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_dual_issue_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dual_issue_scheduler_pkg.sv
// Shared types for the dual-issue scheduler: register address width, FSM
// state encoding, the hold-entry layout and the slot view used by pair_check.
package dual_issue_scheduler_pkg;

    localparam int unsigned RF_ADDR_WIDTH = 5;

    typedef logic [RF_ADDR_WIDTH-1:0] regAddr_t;

    typedef enum logic [0:0] {
        S_NORMAL = 1'b0,
        S_HOLD   = 1'b1
    } schedState_t;

    // Fields kept alongside the held payload while slot 1 waits to issue
    typedef struct packed {
        regAddr_t rs1;
        regAddr_t rs2;
        regAddr_t rd;
        logic     wb;
        logic     ld;
    } holdMeta_t;

    // Per-slot view consumed by the pairing/hazard checker
    typedef struct packed {
        regAddr_t rs1;
        regAddr_t rs2;
        regAddr_t rd;
        logic     wb;
        logic     mem;
        logic     ctl;
    } slotInfo_t;

    // A nonzero source register matching the rd of a load currently in EX
    function automatic logic srcHit(regAddr_t rs, logic ldv, regAddr_t ldRd);
        return (rs != '0) && ldv && (rs == ldRd);
    endfunction

endpackage

// File: rtl/dual_issue_scheduler_pair_check.sv
// Combinational pairing and load-use hazard checks for the decoded pair.
module dual_issue_scheduler_pair_check
    import dual_issue_scheduler_pkg::*;
(
    input  slotInfo_t slot0,
    input  slotInfo_t slot1,
    input  logic      ldv0,
    input  logic      ldv1,
    input  regAddr_t  ldrd0,
    input  regAddr_t  ldrd1,
    output logic      raw,
    output logic      waw,
    output logic      struct_split,
    output logic      luse0,
    output logic      luse1
);

    // Lane 0 owns the memory port, so a memory op in slot 0 never forces a split
    logic unusedSlotBits;
    assign unusedSlotBits = slot0.mem;

    function automatic logic loadUse(slotInfo_t s, logic v0, regAddr_t r0,
                                     logic v1, regAddr_t r1);
        return srcHit(s.rs1, v0, r0) | srcHit(s.rs2, v0, r0) |
               srcHit(s.rs1, v1, r1) | srcHit(s.rs2, v1, r1);
    endfunction

    // Intra-pair dependences, lane restrictions and EX-load hazards
    always_comb begin
        raw          = slot0.wb && (slot0.rd != '0) &&
                       ((slot1.rs1 == slot0.rd) || (slot1.rs2 == slot0.rd));
        waw          = slot0.wb && slot1.wb && (slot0.rd != '0) &&
                       (slot0.rd == slot1.rd);
        struct_split = slot1.mem | slot0.ctl | slot1.ctl;
        luse0        = loadUse(slot0, ldv0, ldrd0, ldv1, ldrd1);
        luse1        = loadUse(slot1, ldv0, ldrd0, ldv1, ldrd1);
    end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler between the IF/ID pair register and ID/EX: pairs,
// splits or bubbles the decoded pair and tracks loads currently in EX.
module dual_issue_scheduler
    import dual_issue_scheduler_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 128,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dec_valid_0,
    input  logic                 dec_valid_1,
    input  logic [PAYLOAD_W-1:0] dec_pay_0,
    input  logic [PAYLOAD_W-1:0] dec_pay_1,
    input  logic [4:0]           dec_rs1_0,
    input  logic [4:0]           dec_rs2_0,
    input  logic [4:0]           dec_rd_0,
    input  logic [4:0]           dec_rs1_1,
    input  logic [4:0]           dec_rs2_1,
    input  logic [4:0]           dec_rd_1,
    input  logic                 dec_wb_0,
    input  logic                 dec_wb_1,
    input  logic                 dec_ld_0,
    input  logic                 dec_ld_1,
    input  logic                 dec_mem_0,
    input  logic                 dec_mem_1,
    input  logic                 dec_ctl_0,
    input  logic                 dec_ctl_1,
    input  logic                 pipe_stall,
    input  logic                 flush,
    output logic                 dec_ready,
    output logic                 iss_valid_0,
    output logic                 iss_valid_1,
    output logic [PAYLOAD_W-1:0] iss_pay_0,
    output logic [PAYLOAD_W-1:0] iss_pay_1,
    output logic [CNT_W-1:0]     split_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    schedState_t          state;
    schedState_t          nextState;
    logic [PAYLOAD_W-1:0] holdPay;
    holdMeta_t            holdMeta;
    logic                 ldv0;
    logic                 ldv1;
    regAddr_t             ldrd0;
    regAddr_t             ldrd1;

    slotInfo_t            chkSlot0;
    slotInfo_t            chkSlot1;
    logic                 raw;
    logic                 waw;
    logic                 structSplit;
    logic                 luse0;
    logic                 luse1;
    logic                 pairSplit;

    logic                 readyRaw;
    logic                 issV0;
    logic                 issV1;
    logic [PAYLOAD_W-1:0] issPay0;
    regAddr_t             issRd0;
    logic                 issLd0;
    logic                 bubble;
    logic                 doSplit;

    // Lane-0 candidate is the held entry in HOLD, otherwise decode slot 0
    always_comb begin
        chkSlot1 = '{rs1: dec_rs1_1, rs2: dec_rs2_1, rd: dec_rd_1,
                     wb: dec_wb_1, mem: dec_mem_1, ctl: dec_ctl_1};
        if (state == S_HOLD) begin
            chkSlot0 = '{rs1: holdMeta.rs1, rs2: holdMeta.rs2, rd: holdMeta.rd,
                         wb: holdMeta.wb, mem: 1'b0, ctl: 1'b0};
            issPay0  = holdPay;
            issRd0   = holdMeta.rd;
            issLd0   = holdMeta.ld;
        end else begin
            chkSlot0 = '{rs1: dec_rs1_0, rs2: dec_rs2_0, rd: dec_rd_0,
                         wb: dec_wb_0, mem: dec_mem_0, ctl: dec_ctl_0};
            issPay0  = dec_pay_0;
            issRd0   = dec_rd_0;
            issLd0   = dec_ld_0;
        end
    end

    dual_issue_scheduler_pair_check uPairCheck (
        .slot0        (chkSlot0),
        .slot1        (chkSlot1),
        .ldv0         (ldv0),
        .ldv1         (ldv1),
        .ldrd0        (ldrd0),
        .ldrd1        (ldrd1),
        .raw          (raw),
        .waw          (waw),
        .struct_split (structSplit),
        .luse0        (luse0),
        .luse1        (luse1)
    );

    assign pairSplit = raw | waw | structSplit | luse1;

    // Next-state and issue decision; flush overrides stall, stall freezes all
    always_comb begin
        nextState = state;
        readyRaw  = 1'b0;
        issV0     = 1'b0;
        issV1     = 1'b0;
        bubble    = 1'b0;
        doSplit   = 1'b0;
        if (flush) begin
            readyRaw  = 1'b1;
            nextState = S_NORMAL;
        end else if (!pipe_stall) begin
            case (state)
                S_NORMAL: begin
                    if (!dec_valid_0) begin
                        readyRaw = 1'b1;
                    end else if (luse0) begin
                        bubble = 1'b1;
                    end else if (!dec_valid_1) begin
                        issV0    = 1'b1;
                        readyRaw = 1'b1;
                    end else if (pairSplit) begin
                        issV0     = 1'b1;
                        doSplit   = 1'b1;
                        nextState = S_HOLD;
                    end else begin
                        issV0    = 1'b1;
                        issV1    = 1'b1;
                        readyRaw = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (luse0) begin
                        bubble = 1'b1;
                    end else begin
                        issV0     = 1'b1;
                        readyRaw  = 1'b1;
                        nextState = S_NORMAL;
                    end
                end
                default: nextState = S_NORMAL;
            endcase
        end
    end

    assign dec_ready   = rst_n & readyRaw;
    assign iss_valid_0 = rst_n & issV0;
    assign iss_valid_1 = rst_n & issV1;
    assign iss_pay_0   = issPay0;
    assign iss_pay_1   = dec_pay_1;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_NORMAL;
        end else begin
            state <= nextState;
        end
    end

    // Hold buffer captures slot 1 when a pair is split
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            holdPay  <= '0;
            holdMeta <= '0;
        end else if (doSplit) begin
            holdPay  <= dec_pay_1;
            holdMeta <= '{rs1: dec_rs1_1, rs2: dec_rs2_1, rd: dec_rd_1,
                          wb: dec_wb_1, ld: dec_ld_1};
        end
    end

    // EX-load trackers follow what enters ID/EX; bubbles and flushes clear them
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            ldv0  <= 1'b0;
            ldv1  <= 1'b0;
            ldrd0 <= '0;
            ldrd1 <= '0;
        end else if (!pipe_stall) begin
            if (bubble) begin
                ldv0  <= 1'b0;
                ldv1  <= 1'b0;
                ldrd0 <= '0;
                ldrd1 <= '0;
            end else begin
                ldv0  <= issV0 & issLd0;
                ldv1  <= issV1 & dec_ld_1;
                ldrd0 <= issRd0;
                ldrd1 <= dec_rd_1;
            end
        end
    end

    // Performance counters, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            split_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (doSplit) begin
                split_cnt <= split_cnt + CNT_W'(1);
            end
            if (bubble) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed table-driven bench for dual_issue_scheduler.
module tb_dual_issue_scheduler;

    localparam int unsigned PW = 128;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dec_valid_0, dec_valid_1;
    logic [PW-1:0] dec_pay_0, dec_pay_1;
    logic [4:0]    dec_rs1_0, dec_rs2_0, dec_rd_0;
    logic [4:0]    dec_rs1_1, dec_rs2_1, dec_rd_1;
    logic          dec_wb_0, dec_wb_1, dec_ld_0, dec_ld_1;
    logic          dec_mem_0, dec_mem_1, dec_ctl_0, dec_ctl_1;
    logic          pipe_stall, flush;
    logic          dec_ready, iss_valid_0, iss_valid_1;
    logic [PW-1:0] iss_pay_0, iss_pay_1;
    logic [CW-1:0] split_cnt, bubble_cnt;

    dual_issue_scheduler #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid_0(dec_valid_0), .dec_valid_1(dec_valid_1),
        .dec_pay_0(dec_pay_0), .dec_pay_1(dec_pay_1),
        .dec_rs1_0(dec_rs1_0), .dec_rs2_0(dec_rs2_0), .dec_rd_0(dec_rd_0),
        .dec_rs1_1(dec_rs1_1), .dec_rs2_1(dec_rs2_1), .dec_rd_1(dec_rd_1),
        .dec_wb_0(dec_wb_0), .dec_wb_1(dec_wb_1),
        .dec_ld_0(dec_ld_0), .dec_ld_1(dec_ld_1),
        .dec_mem_0(dec_mem_0), .dec_mem_1(dec_mem_1),
        .dec_ctl_0(dec_ctl_0), .dec_ctl_1(dec_ctl_1),
        .pipe_stall(pipe_stall), .flush(flush),
        .dec_ready(dec_ready),
        .iss_valid_0(iss_valid_0), .iss_valid_1(iss_valid_1),
        .iss_pay_0(iss_pay_0), .iss_pay_1(iss_pay_1),
        .split_cnt(split_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs1, rs2, rd;
        logic       wb, ld, mem, ctl;
        logic [7:0] tag;
    } ins_t;

    typedef struct {
        ins_t       s0, s1;
        logic       v0, v1, stall, fl;
        logic       eRdy, eV0, eV1;
        logic [7:0] eT0, eT1;
        int         eSplit, eBub;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic ins_t alu(int rd, int rs1, int rs2, int tag);
        return '{rs1: 5'(rs1), rs2: 5'(rs2), rd: 5'(rd), wb: 1'b1, ld: 1'b0,
                 mem: 1'b0, ctl: 1'b0, tag: 8'(tag)};
    endfunction

    function automatic ins_t load(int rd, int rs1, int tag);
        return '{rs1: 5'(rs1), rs2: 5'd0, rd: 5'(rd), wb: 1'b1, ld: 1'b1,
                 mem: 1'b1, ctl: 1'b0, tag: 8'(tag)};
    endfunction

    function automatic ins_t store(int rs1, int rs2, int tag);
        return '{rs1: 5'(rs1), rs2: 5'(rs2), rd: 5'd0, wb: 1'b0, ld: 1'b0,
                 mem: 1'b1, ctl: 1'b0, tag: 8'(tag)};
    endfunction

    function automatic ins_t br(int rs1, int rs2, int tag);
        return '{rs1: 5'(rs1), rs2: 5'(rs2), rd: 5'd0, wb: 1'b0, ld: 1'b0,
                 mem: 1'b0, ctl: 1'b1, tag: 8'(tag)};
    endfunction

    function automatic logic [PW-1:0] payOf(logic [7:0] t);
        return {t, 112'h0, ~t};
    endfunction

    task automatic addv(ins_t s0, ins_t s1, logic v0, logic v1, logic stall,
                        logic fl, logic eRdy, logic eV0, logic eV1,
                        int eT0, int eT1, int eSplit, int eBub);
        vec_t v;
        v.s0 = s0; v.s1 = s1; v.v0 = v0; v.v1 = v1; v.stall = stall; v.fl = fl;
        v.eRdy = eRdy; v.eV0 = eV0; v.eV1 = eV1;
        v.eT0 = 8'(eT0); v.eT1 = 8'(eT1); v.eSplit = eSplit; v.eBub = eBub;
        vecs.push_back(v);
    endtask

    task automatic drive(ins_t s0, ins_t s1, logic v0, logic v1, logic stall, logic fl);
        dec_valid_0 = v0;      dec_valid_1 = v1;
        dec_pay_0   = payOf(s0.tag); dec_pay_1 = payOf(s1.tag);
        dec_rs1_0   = s0.rs1;  dec_rs2_0 = s0.rs2; dec_rd_0 = s0.rd;
        dec_rs1_1   = s1.rs1;  dec_rs2_1 = s1.rs2; dec_rd_1 = s1.rd;
        dec_wb_0    = s0.wb;   dec_wb_1  = s1.wb;
        dec_ld_0    = s0.ld;   dec_ld_1  = s1.ld;
        dec_mem_0   = s0.mem;  dec_mem_1 = s1.mem;
        dec_ctl_0   = s0.ctl;  dec_ctl_1 = s1.ctl;
        pipe_stall  = stall;   flush     = fl;
    endtask

    task automatic chk(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t nop;
        nop = '0;

        // Sequential vectors; counters are the totals before each vector's edge
        addv(alu(1,2,3,'h10),  alu(4,5,6,'h11),  1,1,0,0, 1,1,1, 'h10,'h11, 0,0);
        addv(alu(5,1,2,'h20),  alu(7,5,3,'h21),  1,1,0,0, 0,1,0, 'h20,0,    0,0);
        addv(alu(5,1,2,'h20),  alu(7,5,3,'h21),  1,1,0,0, 1,1,0, 'h21,0,    1,0);
        addv(load(7,2,'h30),   alu(8,9,10,'h31), 1,1,0,0, 1,1,1, 'h30,'h31, 1,0);
        addv(alu(11,1,7,'h40), alu(12,2,3,'h41), 1,1,0,0, 0,0,0, 0,0,       1,0);
        addv(alu(11,1,7,'h40), alu(12,2,3,'h41), 1,1,0,0, 1,1,1, 'h40,'h41, 1,1);
        addv(load(7,2,'h50),   alu(13,3,4,'h51), 1,1,0,0, 1,1,1, 'h50,'h51, 1,1);
        addv(alu(14,1,2,'h60), alu(15,7,3,'h61), 1,1,0,0, 0,1,0, 'h60,0,    1,1);
        addv(alu(14,1,2,'h60), alu(15,7,3,'h61), 1,1,0,0, 1,1,0, 'h61,0,    2,1);
        addv(alu(16,1,2,'h70), store(3,4,'h71),  1,1,0,0, 0,1,0, 'h70,0,    2,1);
        addv(alu(16,1,2,'h70), store(3,4,'h71),  1,1,0,0, 1,1,0, 'h71,0,    3,1);
        addv(alu(17,1,2,'h80), alu(18,17,3,'h81),1,1,0,0, 0,1,0, 'h80,0,    3,1);
        for (int k = 0; k < 3; k++)
            addv(alu(17,1,2,'h80), alu(18,17,3,'h81),1,1,1,0, 0,0,0, 0,0,   4,1);
        addv(alu(17,1,2,'h80), alu(18,17,3,'h81),1,1,0,0, 1,1,0, 'h81,0,    4,1);
        addv(load(9,1,'h90),   alu(20,9,2,'h91), 1,1,0,0, 0,1,0, 'h90,0,    4,1);
        addv(load(9,1,'h90),   alu(20,9,2,'h91), 1,1,0,1, 1,0,0, 0,0,       5,1);
        addv(alu(21,9,9,'hA0), alu(22,1,2,'hA1), 1,1,0,0, 1,1,1, 'hA0,'hA1, 5,1);
        addv(load(9,1,'hB0),   alu(23,9,2,'hB1), 1,1,0,0, 0,1,0, 'hB0,0,    5,1);
        addv(load(9,1,'hB0),   alu(23,9,2,'hB1), 1,1,0,0, 0,0,0, 0,0,       6,1);
        addv(load(9,1,'hB0),   alu(23,9,2,'hB1), 1,1,0,0, 1,1,0, 'hB1,0,    6,2);
        addv(alu(5,1,2,'hC0),  alu(5,3,4,'hC1),  1,1,0,0, 0,1,0, 'hC0,0,    6,2);
        addv(alu(5,1,2,'hC0),  alu(5,3,4,'hC1),  1,1,0,0, 1,1,0, 'hC1,0,    7,2);
        addv(br(1,2,'hD0),     alu(6,3,4,'hD1),  1,1,0,0, 0,1,0, 'hD0,0,    7,2);
        addv(br(1,2,'hD0),     alu(6,3,4,'hD1),  1,1,0,0, 1,1,0, 'hD1,0,    8,2);
        addv(alu(24,1,2,'hE0), nop,              1,0,0,0, 1,1,0, 'hE0,0,    8,2);
        addv(nop,              nop,              0,0,0,0, 1,0,0, 0,0,       8,2);
        addv(alu(0,1,2,'hF0),  alu(0,0,0,'hF1),  1,1,0,0, 1,1,1, 'hF0,'hF1, 8,2);
        addv(alu(1,2,3,'h10),  alu(4,5,6,'h11),  1,1,1,0, 0,0,0, 0,0,       8,2);
        addv(alu(1,2,3,'h10),  alu(4,5,6,'h11),  1,1,0,0, 1,1,1, 'h10,'h11, 8,2);

        // Reset: outputs forced low while rst_n is asserted
        rst_n = 1'b0;
        drive(nop, nop, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(alu(1,2,3,'h10), alu(4,5,6,'h11), 1, 1, 0, 0);
        #2;
        chk("rst.rdy", PW'(dec_ready), PW'(0));
        chk("rst.v0", PW'(iss_valid_0), PW'(0));
        chk("rst.v1", PW'(iss_valid_1), PW'(0));
        chk("rst.split", PW'(split_cnt), PW'(0));
        chk("rst.bubble", PW'(bubble_cnt), PW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(nop, nop, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].s0, vecs[i].s1, vecs[i].v0, vecs[i].v1, vecs[i].stall, vecs[i].fl);
            #2;
            chk($sformatf("v%0d.rdy", i), PW'(dec_ready), PW'(vecs[i].eRdy));
            chk($sformatf("v%0d.v0", i), PW'(iss_valid_0), PW'(vecs[i].eV0));
            chk($sformatf("v%0d.v1", i), PW'(iss_valid_1), PW'(vecs[i].eV1));
            if (vecs[i].eV0)
                chk($sformatf("v%0d.pay0", i), iss_pay_0, payOf(vecs[i].eT0));
            if (vecs[i].eV1)
                chk($sformatf("v%0d.pay1", i), iss_pay_1, payOf(vecs[i].eT1));
            chk($sformatf("v%0d.split", i), PW'(split_cnt), PW'(vecs[i].eSplit));
            chk($sformatf("v%0d.bubble", i), PW'(bubble_cnt), PW'(vecs[i].eBub));
        end

        // Reset asserted while a split pair is held discards the held entry
        @(negedge clk);
        drive(alu(5,1,2,'h20), alu(7,5,3,'h21), 1, 1, 0, 0);
        #2;
        chk("hrst.split_v0", PW'(iss_valid_0), PW'(1));
        chk("hrst.split_rdy", PW'(dec_ready), PW'(0));
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("hrst.in_rst_v0", PW'(iss_valid_0), PW'(0));
        chk("hrst.in_rst_rdy", PW'(dec_ready), PW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(alu(1,2,3,'h10), alu(4,5,6,'h11), 1, 1, 0, 0);
        #2;
        chk("hrst.split", PW'(split_cnt), PW'(0));
        chk("hrst.bubble", PW'(bubble_cnt), PW'(0));
        chk("hrst.rdy", PW'(dec_ready), PW'(1));
        chk("hrst.v0", PW'(iss_valid_0), PW'(1));
        chk("hrst.v1", PW'(iss_valid_1), PW'(1));
        chk("hrst.pay0", iss_pay_0, payOf(8'h10));
        chk("hrst.pay1", iss_pay_1, payOf(8'h11));

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
